// File: rtl/phaethon_alu.sv
// Multi-cycle 32-bit register core: fetches instruction words over a req/ack RAM
// handshake, executes a small ISA and counts retired instructions in debug.
module phaethon_alu #(
    parameter logic [7:0] RESET_IP = 8'h00,
    parameter int         NUM_REGS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ramValue,
    input  logic        readAck,
    input  logic        writeAck,
    output logic [31:0] ramAddress,
    output logic [31:0] ramOut,
    output logic        readReq,
    output logic        writeReq,
    output logic [7:0]  iPointer,
    output logic [7:0]  opCode,
    output logic [31:0] r0,
    output logic [31:0] r1,
    output logic [31:0] r2,
    output logic [31:0] debug
);
    localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [7:0] OP_MOVC  = 8'h01, OP_MOV  = 8'h02, OP_ADD = 8'h03,
                           OP_SUB   = 8'h04, OP_AND  = 8'h05, OP_OR  = 8'h06,
                           OP_XOR   = 8'h07, OP_INC  = 8'h08, OP_DEC = 8'h09,
                           OP_LOAD  = 8'h0A, OP_STORE = 8'h0B, OP_JMP = 8'h0C,
                           OP_JNZ   = 8'h0D, OP_HALT = 8'h0E;

    typedef enum logic [2:0] {
        S_FETCH, S_FETCH_W, S_EXEC, S_IMM, S_IMM_W, S_MEM, S_MEM_W, S_HALT
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    ip_q, ip_d;
    logic [31:0]   instr_q, instr_d;
    logic [7:0]    op_q, op_d;
    logic [31:0]   debug_q, debug_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          rreq_q, rreq_d;
    logic          wreq_q, wreq_d;
    logic [31:0]   regs_q [NUM_REGS];
    logic [31:0]   regs_d [NUM_REGS];

    logic [RW-1:0] rd, rs;
    logic [7:0]    imm8, ip_plus4;
    logic [31:0]   a, b;

    assign rd       = instr_q[8 +: RW];
    assign rs       = instr_q[16 +: RW];
    assign imm8     = instr_q[31:24];
    assign a        = regs_q[rd];
    assign b        = regs_q[rs];
    assign ip_plus4 = ip_q + 8'd4;

    always_comb begin
        state_d = state_q;
        ip_d    = ip_q;
        instr_d = instr_q;
        op_d    = op_q;
        debug_d = debug_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rreq_d  = 1'b0;
        wreq_d  = 1'b0;
        regs_d  = regs_q;

        case (state_q)
            S_FETCH: begin
                addr_d  = {24'h0, ip_q};
                rreq_d  = 1'b1;
                state_d = S_FETCH_W;
            end
            S_FETCH_W: begin
                if (readAck) begin
                    instr_d = ramValue;
                    op_d    = ramValue[7:0];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Single-cycle ops retire here; multi-cycle ones retire in their wait state.
                state_d = S_FETCH;
                ip_d    = ip_plus4;
                debug_d = debug_q + 32'd1;
                case (op_q)
                    OP_MOVC: begin
                        ip_d    = ip_q;
                        debug_d = debug_q;
                        state_d = S_IMM;
                    end
                    OP_MOV: regs_d[rd] = b;
                    OP_ADD: regs_d[rd] = a + b;
                    OP_SUB: regs_d[rd] = a - b;
                    OP_AND: regs_d[rd] = a & b;
                    OP_OR:  regs_d[rd] = a | b;
                    OP_XOR: regs_d[rd] = a ^ b;
                    OP_INC: regs_d[rd] = a + 32'd1;
                    OP_DEC: regs_d[rd] = a - 32'd1;
                    OP_LOAD, OP_STORE: begin
                        ip_d    = ip_q;
                        debug_d = debug_q;
                        state_d = S_MEM;
                    end
                    OP_JMP: ip_d = imm8;
                    OP_JNZ: if (a != 32'd0) ip_d = imm8;
                    OP_HALT: begin
                        ip_d    = ip_q;
                        state_d = S_HALT;
                    end
                    default: ;
                endcase
            end
            S_IMM: begin
                addr_d  = {24'h0, ip_plus4};
                rreq_d  = 1'b1;
                state_d = S_IMM_W;
            end
            S_IMM_W: begin
                if (readAck) begin
                    regs_d[rd] = ramValue;
                    ip_d       = ip_q + 8'd8;
                    debug_d    = debug_q + 32'd1;
                    state_d    = S_FETCH;
                end
            end
            S_MEM: begin
                if (op_q == OP_STORE) begin
                    addr_d  = a;
                    wdata_d = b;
                    wreq_d  = 1'b1;
                end else begin
                    addr_d  = b;
                    rreq_d  = 1'b1;
                end
                state_d = S_MEM_W;
            end
            S_MEM_W: begin
                // Only the ack matching the outstanding request direction completes it.
                if ((op_q == OP_STORE) ? writeAck : readAck) begin
                    if (op_q == OP_LOAD) regs_d[rd] = ramValue;
                    ip_d    = ip_plus4;
                    debug_d = debug_q + 32'd1;
                    state_d = S_FETCH;
                end
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            ip_q    <= RESET_IP;
            instr_q <= 32'h0;
            op_q    <= 8'h0;
            debug_q <= 32'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rreq_q  <= 1'b0;
            wreq_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 32'h0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            instr_q <= instr_d;
            op_q    <= op_d;
            debug_q <= debug_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rreq_q  <= rreq_d;
            wreq_q  <= wreq_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign ramAddress = addr_q;
    assign ramOut     = wdata_q;
    assign readReq    = rreq_q;
    assign writeReq   = wreq_q;
    assign iPointer   = ip_q;
    assign opCode     = op_q;
    assign debug      = debug_q;
    assign r0         = regs_q[0];
    assign r1         = regs_q[1];
    assign r2         = regs_q[2];
endmodule

// File: tb/tb_phaethon_alu.sv
// Scoreboarded bench: directed programs push expected per-instruction snapshots;
// a monitor pops one whenever debug advances. A RAM model answers requests.
module tb_phaethon_alu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ramValue;
    logic        readAck, writeAck;
    logic [31:0] ramAddress, ramOut, r0, r1, r2, debug;
    logic        readReq, writeReq;
    logic [7:0]  iPointer, opCode;

    phaethon_alu #(.RESET_IP(8'h00), .NUM_REGS(4)) dut (
        .clk(clk), .reset(reset), .ramValue(ramValue), .readAck(readAck),
        .writeAck(writeAck), .ramAddress(ramAddress), .ramOut(ramOut),
        .readReq(readReq), .writeReq(writeReq), .iPointer(iPointer),
        .opCode(opCode), .r0(r0), .r1(r1), .r2(r2), .debug(debug)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ip;
        logic [31:0] r0, r1, r2, dbg;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0, n_bad = 0;
    logic [7:0] mem [256];
    int dly = 0;
    bit spur = 0, stray = 0;
    int nreq = 0, nwr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] ip, input logic [31:0] a, b, c, d);
        exp_t e;
        e.ip = ip; e.r0 = a; e.r1 = b; e.r2 = c; e.dbg = d;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] ins(input logic [7:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {imm, 6'b0, rs, 6'b0, rd, op};
    endfunction

    task automatic put(input logic [7:0] addr, input logic [31:0] w);
        for (int k = 0; k < 4; k++) mem[addr + 8'(k)] = w[8*k +: 8];
    endtask

    // RAM model: answers one request at a time after dly negedges and polices the handshake.
    logic        pend = 0, p_rd;
    logic [31:0] p_addr, p_data;
    logic [7:0]  p_ip;
    int          cnt;

    task automatic deliver();
        if (p_rd) begin
            for (int k = 0; k < 4; k++) ramValue[8*k +: 8] = mem[p_addr[7:0] + 8'(k)];
            readAck = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) mem[p_addr[7:0] + 8'(k)] = p_data[8*k +: 8];
            writeAck = 1'b1;
        end
    endtask

    initial begin
        readAck = 0; writeAck = 0; ramValue = 32'hA5A5A5A5;
        forever begin
            @(negedge clk);
            readAck = 0; writeAck = 0; ramValue = 32'hA5A5A5A5;
            if (!reset) begin
                pend = 0;
            end else if (pend) begin
                chk("req_during_wait", {30'b0, readReq, writeReq}, 32'h0);
                chk("addr_stable", ramAddress, p_addr);
                chk("ip_stable", {24'h0, iPointer}, {24'h0, p_ip});
                if (spur && p_rd && cnt == 3) writeAck = 1'b1;
                cnt--;
                if (cnt == 0) begin
                    deliver();
                    pend = 0;
                end
            end else if (readReq || writeReq) begin
                chk("one_req_dir", {31'b0, readReq & writeReq}, 32'h0);
                p_rd = readReq; p_addr = ramAddress; p_data = ramOut; p_ip = iPointer;
                nreq++;
                if (writeReq) nwr++;
                if (dly == 0) deliver();
                else begin
                    pend = 1; cnt = dly;
                end
            end else if (stray) begin
                readAck = 1'b1; writeAck = 1'b1; ramValue = 32'h0000_0009;
                stray = 0;
            end
        end
    end

    // Monitor: each retired instruction advances debug; compare architectural state.
    logic [31:0] prev_dbg = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) prev_dbg = 0;
            else if (debug !== prev_dbg) begin
                prev_dbg = debug;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_retire: debug=%h ip=%h with no expected entry", debug, iPointer);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (iPointer !== e.ip || r0 !== e.r0 || r1 !== e.r1 || r2 !== e.r2 || debug !== e.dbg) begin
                        n_bad++;
                        $display("FAIL retire: got ip=%h r0=%h r1=%h r2=%h dbg=%h expected ip=%h r0=%h r1=%h r2=%h dbg=%h",
                                 iPointer, r0, r1, r2, debug, e.ip, e.r0, e.r1, e.r2, e.dbg);
                    end
                end
            end
        end
    end

    task automatic begin_prog(input int d, input bit s);
        @(negedge clk);
        reset = 0;
        dly = d; spur = s;
        sb.delete();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        nreq = 0; nwr = 0;
    endtask

    task automatic release_rst();
        repeat (2) @(negedge clk);
        reset = 1;
    endtask

    task automatic run_until(input logic [31:0] dbg, input int budget);
        int n = 0;
        while (debug !== dbg && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("reach_debug", debug, dbg);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int hold;
        #3 reset = 0;

        // Decrement loop, with reset checks on the way in.
        begin_prog(0, 0);
        put(8'h00, ins(8'h01, 0, 0, 0));
        put(8'h04, 32'h3);
        put(8'h08, ins(8'h09, 0, 0, 0));
        put(8'h0C, ins(8'h0D, 0, 0, 8'h08));
        put(8'h10, ins(8'h0E, 0, 0, 0));
        push(8'h08, 3, 0, 0, 1);
        push(8'h0C, 2, 0, 0, 2);
        push(8'h08, 2, 0, 0, 3);
        push(8'h0C, 1, 0, 0, 4);
        push(8'h08, 1, 0, 0, 5);
        push(8'h0C, 0, 0, 0, 6);
        push(8'h10, 0, 0, 0, 7);
        push(8'h10, 0, 0, 0, 8);
        repeat (2) @(negedge clk);
        chk("rst_ramAddress", ramAddress, 0);
        chk("rst_ramOut", ramOut, 0);
        chk("rst_reqs", {30'b0, readReq, writeReq}, 0);
        chk("rst_ip_op", {16'h0, iPointer, opCode}, 0);
        chk("rst_regs", r0 | r1 | r2, 0);
        chk("rst_debug", debug, 0);
        reset = 1;
        @(negedge clk);
        chk("first_readReq", {31'b0, readReq}, 1);
        chk("first_addr", ramAddress, 0);
        run_until(8, 400);
        hold = nreq;
        repeat (5) @(negedge clk);
        stray = 1;
        repeat (15) @(negedge clk);
        chk("halt_no_req", nreq, hold);
        chk("halt_ip", {24'h0, iPointer}, 32'h10);
        chk("halt_opcode", {24'h0, opCode}, 32'h0E);
        chk("halt_debug", debug, 8);

        // ALU ops, wrap-around, rd==rs, JMP.
        begin_prog(1, 0);
        put(8'h00, ins(8'h01, 1, 0, 0));  put(8'h04, 32'd5);
        put(8'h08, ins(8'h01, 2, 0, 0));  put(8'h0C, 32'd7);
        put(8'h10, ins(8'h03, 1, 2, 0));
        put(8'h14, ins(8'h04, 2, 1, 0));
        put(8'h18, ins(8'h09, 0, 0, 0));
        put(8'h1C, ins(8'h08, 0, 0, 0));
        put(8'h20, ins(8'h02, 0, 2, 0));
        put(8'h24, ins(8'h05, 0, 1, 0));
        put(8'h28, ins(8'h06, 0, 1, 0));
        put(8'h2C, ins(8'h07, 1, 1, 0));
        put(8'h30, ins(8'h0C, 0, 0, 8'h3C));
        put(8'h34, ins(8'h08, 0, 0, 0));
        put(8'h38, ins(8'h08, 0, 0, 0));
        put(8'h3C, ins(8'h0E, 0, 0, 0));
        push(8'h08, 0, 5, 0, 1);
        push(8'h10, 0, 5, 7, 2);
        push(8'h14, 0, 32'hC, 7, 3);
        push(8'h18, 0, 32'hC, 32'hFFFFFFFB, 4);
        push(8'h1C, 32'hFFFFFFFF, 32'hC, 32'hFFFFFFFB, 5);
        push(8'h20, 0, 32'hC, 32'hFFFFFFFB, 6);
        push(8'h24, 32'hFFFFFFFB, 32'hC, 32'hFFFFFFFB, 7);
        push(8'h28, 32'h8, 32'hC, 32'hFFFFFFFB, 8);
        push(8'h2C, 32'hC, 32'hC, 32'hFFFFFFFB, 9);
        push(8'h30, 32'hC, 0, 32'hFFFFFFFB, 10);
        push(8'h3C, 32'hC, 0, 32'hFFFFFFFB, 11);
        push(8'h3C, 32'hC, 0, 32'hFFFFFFFB, 12);
        release_rst();
        run_until(12, 600);

        // STORE then LOAD through RAM.
        begin_prog(2, 0);
        put(8'h00, ins(8'h01, 0, 0, 0));  put(8'h04, 32'h40);
        put(8'h08, ins(8'h01, 1, 0, 0));  put(8'h0C, 32'hDEADBEEF);
        put(8'h10, ins(8'h0B, 0, 1, 0));
        put(8'h14, ins(8'h0A, 2, 0, 0));
        put(8'h18, ins(8'h0E, 0, 0, 0));
        push(8'h08, 32'h40, 0, 0, 1);
        push(8'h10, 32'h40, 32'hDEADBEEF, 0, 2);
        push(8'h14, 32'h40, 32'hDEADBEEF, 0, 3);
        push(8'h18, 32'h40, 32'hDEADBEEF, 32'hDEADBEEF, 4);
        push(8'h18, 32'h40, 32'hDEADBEEF, 32'hDEADBEEF, 5);
        release_rst();
        run_until(5, 400);
        chk("mem_bytes", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'hDEADBEEF);
        chk("mem_byte40", {24'h0, mem[8'h40]}, 32'hEF);
        chk("write_count", nwr, 1);
        chk("ramOut_hold", ramOut, 32'hDEADBEEF);

        // Slow acks with a stray writeAck mid-fetch.
        begin_prog(5, 1);
        put(8'h00, ins(8'h00, 0, 0, 0));
        put(8'h04, ins(8'h08, 2, 0, 0));
        put(8'h08, ins(8'h0E, 0, 0, 0));
        push(8'h04, 0, 0, 0, 1);
        push(8'h08, 0, 0, 1, 2);
        push(8'h08, 0, 0, 1, 3);
        release_rst();
        run_until(3, 400);
        chk("slow_req_count", nreq, 3);

        // Unknown opcode behaves as NOP.
        begin_prog(3, 0);
        put(8'h00, ins(8'hFF, 1, 2, 8'h33));
        put(8'h04, ins(8'h0E, 0, 0, 0));
        push(8'h04, 0, 0, 0, 1);
        push(8'h04, 0, 0, 0, 2);
        release_rst();
        run_until(2, 400);
        chk("unk_regs", r0 | r1 | r2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
